// File: rtl/core101_alu_pkg.sv
// Shared definitions for the core101 EX-stage ALU:
// micro-op encodings, FSM states and width helpers.
package core101_alu_pkg;

  localparam logic [4:0] UOP_ADD    = 5'h00;
  localparam logic [4:0] UOP_SUB    = 5'h01;
  localparam logic [4:0] UOP_OR     = 5'h02;
  localparam logic [4:0] UOP_AND    = 5'h03;
  localparam logic [4:0] UOP_XOR    = 5'h04;
  localparam logic [4:0] UOP_BUF_A  = 5'h08;
  localparam logic [4:0] UOP_BUF_B  = 5'h09;
  localparam logic [4:0] UOP_SLT    = 5'h0A;
  localparam logic [4:0] UOP_SLTU   = 5'h0B;
  localparam logic [4:0] UOP_SRA    = 5'h0D;
  localparam logic [4:0] UOP_SRL    = 5'h0E;
  localparam logic [4:0] UOP_SLL    = 5'h0F;

  localparam logic [4:0] UOP_MUL    = 5'h10;
  localparam logic [4:0] UOP_MULH   = 5'h11;
  localparam logic [4:0] UOP_MULHSU = 5'h12;
  localparam logic [4:0] UOP_MULHU  = 5'h13;
  localparam logic [4:0] UOP_DIV    = 5'h14;
  localparam logic [4:0] UOP_DIVU   = 5'h15;
  localparam logic [4:0] UOP_REM    = 5'h16;
  localparam logic [4:0] UOP_REMU   = 5'h17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  function automatic logic [63:0] min_signed(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] all_ones(input int unsigned w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle unsigned multiplier / restoring divider.
// Both share a single W+1-bit adder; hi:lo holds product or rem:quot.
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(W);

  logic          busy;
  logic          mode_div;
  logic [CW-1:0] cnt;
  logic [W-1:0]  opnd;
  logic [W:0]    add_x;
  logic [W:0]    add_y;
  logic [W:0]    add_s;
  logic          add_ci;
  logic          add_co;

  assign done = busy & (cnt == '0);

  // divide: trial subtract of the divisor from the shifted remainder
  always_comb begin
    add_x  = {1'b0, hi};
    add_y  = lo[0] ? {1'b0, opnd} : '0;
    add_ci = 1'b0;
    if (mode_div) begin
      add_x  = {hi, lo[W-1]};
      add_y  = ~{1'b0, opnd};
      add_ci = 1'b1;
    end
  end

  assign {add_co, add_s} = {1'b0, add_x} + {1'b0, add_y}
                         + {{(W+1){1'b0}}, add_ci};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      mode_div <= 1'b0;
      cnt      <= '0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (clear) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      mode_div <= is_div;
      cnt      <= CW'(W - 1);
      opnd     <= b;
      hi       <= '0;
      lo       <= a;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (done) busy <= 1'b0;
      if (mode_div) begin
        hi <= add_co ? add_s[W-1:0] : add_x[W-1:0];
        lo <= {lo[W-2:0], add_co};
      end else begin
        hi <= add_s[W:1];
        lo <= {add_s[0], lo[W-1:1]};
      end
    end
  end

endmodule

// File: rtl/pipelined_muldiv_alu.sv
// EX-stage integer ALU: single-cycle base ops, iterative RV32M mul/div,
// valid/ready on both sides with a held output register.
module pipelined_muldiv_alu
  import core101_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] a_data_in,
  input  logic [DATA_WIDTH-1:0] b_data_in,
  input  logic [4:0]            uop_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] result_out
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_S = W'(min_signed(W));
  localparam logic [W-1:0] ONES  = W'(all_ones(W));

  state_t             state;
  logic [2:0]         mop;
  logic               neg_res;

  logic               accept;
  logic               is_md;
  logic               is_div;
  logic               a_sgn;
  logic               b_sgn;
  logic               a_neg;
  logic               b_neg;
  logic               dz;
  logic               ovf;
  logic               start;
  logic               neg_now;
  logic [W-1:0]       a_mag;
  logic [W-1:0]       b_mag;
  logic [SHAMT_W-1:0] shamt;
  logic [W-1:0]       base_res;
  logic [W-1:0]       quick_res;
  logic [W-1:0]       load_now;

  logic               iter_done;
  logic [W-1:0]       iter_hi;
  logic [W-1:0]       iter_lo;
  logic [2*W-1:0]     prod;
  logic [2*W-1:0]     prod_fix;
  logic [W-1:0]       quot_fix;
  logic [W-1:0]       rem_fix;
  logic [W-1:0]       fix_res;

  assign ready_out = (state == ST_IDLE) & (~valid_out | ready_in);
  assign accept    = valid_in & ready_out & ~flush_in;

  assign is_md  = uop_in[4] & ~uop_in[3];
  assign is_div = is_md & uop_in[2];
  assign a_sgn  = (uop_in == UOP_MULH) | (uop_in == UOP_MULHSU)
                | (uop_in == UOP_DIV)  | (uop_in == UOP_REM);
  assign b_sgn  = (uop_in == UOP_MULH) | (uop_in == UOP_DIV)
                | (uop_in == UOP_REM);
  assign a_neg  = a_sgn & a_data_in[W-1];
  assign b_neg  = b_sgn & b_data_in[W-1];
  assign a_mag  = a_neg ? -a_data_in : a_data_in;
  assign b_mag  = b_neg ? -b_data_in : b_data_in;

  // remainder sign follows the dividend only
  assign neg_now = a_neg ^ (b_neg & ~(is_div & uop_in[1]));

  assign dz    = is_div & (b_data_in == '0);
  assign ovf   = is_div & ~uop_in[0]
               & (a_data_in == MIN_S) & (b_data_in == ONES);
  assign start = accept & is_md & ~dz & ~ovf;

  always_comb begin
    quick_res = '0;
    if (dz) begin
      quick_res = uop_in[1] ? a_data_in : ONES;
    end else if (ovf) begin
      quick_res = uop_in[1] ? '0 : MIN_S;
    end
  end

  assign shamt = b_data_in[SHAMT_W-1:0];

  always_comb begin
    base_res = '0;
    case (uop_in)
      UOP_ADD:   base_res = a_data_in + b_data_in;
      UOP_SUB:   base_res = a_data_in - b_data_in;
      UOP_OR:    base_res = a_data_in | b_data_in;
      UOP_AND:   base_res = a_data_in & b_data_in;
      UOP_XOR:   base_res = a_data_in ^ b_data_in;
      UOP_BUF_A: base_res = a_data_in;
      UOP_BUF_B: base_res = b_data_in;
      UOP_SLT:   base_res = W'($signed(a_data_in) < $signed(b_data_in));
      UOP_SLTU:  base_res = W'(a_data_in < b_data_in);
      UOP_SRA:   base_res = $signed(a_data_in) >>> shamt;
      UOP_SRL:   base_res = a_data_in >> shamt;
      UOP_SLL:   base_res = a_data_in << shamt;
      default:   base_res = '0;
    endcase
  end

  assign load_now = uop_in[4] ? quick_res : base_res;

  muldiv_iter #(
    .W (W)
  ) u_iter (
    .clk    (clock_in),
    .rst    (reset_in),
    .clear  (flush_in),
    .start  (start),
    .is_div (is_div),
    .a      (a_mag),
    .b      (b_mag),
    .done   (iter_done),
    .hi     (iter_hi),
    .lo     (iter_lo)
  );

  assign prod     = {iter_hi, iter_lo};
  assign prod_fix = neg_res ? -prod : prod;
  assign quot_fix = neg_res ? -iter_lo : iter_lo;
  assign rem_fix  = neg_res ? -iter_hi : iter_hi;

  always_comb begin
    case ({2'b10, mop})
      UOP_MUL:                        fix_res = prod_fix[W-1:0];
      UOP_MULH, UOP_MULHSU, UOP_MULHU: fix_res = prod_fix[2*W-1:W];
      UOP_DIV, UOP_DIVU:              fix_res = quot_fix;
      UOP_REM, UOP_REMU:              fix_res = rem_fix;
      default:                        fix_res = '0;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= ST_IDLE;
      valid_out  <= 1'b0;
      result_out <= '0;
      mop        <= '0;
      neg_res    <= 1'b0;
    end else if (flush_in) begin
      state     <= ST_IDLE;
      valid_out <= 1'b0;
    end else begin
      if (ready_in) valid_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= is_div ? ST_DIV : ST_MUL;
            mop     <= uop_in[2:0];
            neg_res <= neg_now;
          end else if (accept) begin
            result_out <= load_now;
            valid_out  <= 1'b1;
          end
        end
        ST_MUL, ST_DIV: begin
          if (iter_done) state <= ST_FIX;
        end
        ST_FIX: begin
          // wait here while the previous result is still held
          if (~valid_out | ready_in) begin
            result_out <= fix_res;
            valid_out  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_muldiv_alu.sv
// Bench for pipelined_muldiv_alu: directed table, handshake corner
// sequences and random ops against an arithmetic reference, W=32 and W=16.
module tb_pipelined_muldiv_alu;
  import core101_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ready_in;

  logic        valid_in;
  logic [4:0]  uop;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        ready_out;
  logic        valid_out;

  logic        v16_in;
  logic [4:0]  uop16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [15:0] res16;
  logic        rdy16;
  logic        v16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipelined_muldiv_alu #(.DATA_WIDTH(32)) dut (
    .clock_in   (clk),
    .reset_in   (rst),
    .flush_in   (flush),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .a_data_in  (a),
    .b_data_in  (b),
    .uop_in     (uop),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .result_out (result)
  );

  pipelined_muldiv_alu #(.DATA_WIDTH(16)) dut16 (
    .clock_in   (clk),
    .reset_in   (rst),
    .flush_in   (flush),
    .valid_in   (v16_in),
    .ready_out  (rdy16),
    .a_data_in  (a16),
    .b_data_in  (b16),
    .uop_in     (uop16),
    .valid_out  (v16),
    .ready_in   (ready_in),
    .result_out (res16)
  );

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on 64-bit values.
  function automatic logic [63:0] model(input int w, input logic [4:0] u,
                                        input logic [63:0] x,
                                        input logic [63:0] y);
    logic [63:0] m;
    longint sx, sy, mn;
    logic [63:0] r;
    int sh;
    m  = (64'd1 << w) - 64'd1;
    x  = x & m;
    y  = y & m;
    sx = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
    sy = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
    mn = -(longint'(1) << (w - 1));
    sh = int'(y[31:0]) & (w - 1);
    r  = 0;
    case (u)
      5'h00: r = x + y;
      5'h01: r = x - y;
      5'h02: r = x | y;
      5'h03: r = x & y;
      5'h04: r = x ^ y;
      5'h08: r = x;
      5'h09: r = y;
      5'h0A: r = (sx < sy) ? 64'd1 : 64'd0;
      5'h0B: r = (x < y) ? 64'd1 : 64'd0;
      5'h0D: r = sx >>> sh;
      5'h0E: r = x >> sh;
      5'h0F: r = x << sh;
      5'h10: r = x * y;
      5'h11: r = (sx * sy) >>> w;
      5'h12: r = (sx * longint'(y)) >>> w;
      5'h13: r = (x * y) >> w;
      5'h14: if (y == 0) r = '1;
             else if (sx == mn && sy == -1) r = x;
             else r = sx / sy;
      5'h15: if (y == 0) r = '1; else r = x / y;
      5'h16: if (y == 0) r = x;
             else if (sx == mn && sy == -1) r = 0;
             else r = sx % sy;
      5'h17: if (y == 0) r = x; else r = x % y;
      default: r = 0;
    endcase
    return r & m;
  endfunction

  function automatic int lat_model(input int w, input logic [4:0] u,
                                   input logic [63:0] x,
                                   input logic [63:0] y);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    x = x & m;
    y = y & m;
    if (u[4:3] != 2'b10) return 0;
    if (u[2] && y == 0) return 0;
    if (u[2] && !u[0] && x == (64'd1 << (w - 1)) && y == m) return 0;
    return w + 1;
  endfunction

  // called at a negedge with the DUT able to accept
  task automatic run32(input logic [4:0] u, input logic [31:0] x,
                       input logic [31:0] y, output logic [31:0] res,
                       output int lat, output bit leak);
    uop = u; a = x; b = y; valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    lat = 0;
    leak = 1'b0;
    while (!valid_out && lat < 100) begin
      if (ready_out) leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic run16(input logic [4:0] u, input logic [15:0] x,
                       input logic [15:0] y, output logic [15:0] res,
                       output int lat);
    uop16 = u; a16 = x; b16 = y; v16_in = 1'b1;
    check("w16_ready", rdy16, 1);
    @(posedge clk);
    @(negedge clk);
    v16_in = 1'b0;
    lat = 0;
    while (!v16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = res16;
  endtask

  typedef struct {
    logic [4:0]  u;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] res;
  logic [15:0] r16;
  int          lat;
  bit          leak;
  logic [4:0]  u;
  logic [31:0] x;
  logic [31:0] y;
  logic [63:0] e;
  int          el;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(vec_t'{UOP_ADD,    32'd7,        32'd5,        32'd12,       0});
    tbl.push_back(vec_t'{UOP_SUB,    32'd5,        32'd7,        32'hFFFFFFFE, 0});
    tbl.push_back(vec_t'{UOP_OR,     32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 0});
    tbl.push_back(vec_t'{UOP_AND,    32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0});
    tbl.push_back(vec_t'{UOP_XOR,    32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 0});
    tbl.push_back(vec_t'{UOP_BUF_A,  32'h12345678, 32'd1,        32'h12345678, 0});
    tbl.push_back(vec_t'{UOP_BUF_B,  32'd1,        32'hDEADBEEF, 32'hDEADBEEF, 0});
    tbl.push_back(vec_t'{UOP_SLT,    32'hFFFFFFFF, 32'd1,        32'd1,        0});
    tbl.push_back(vec_t'{UOP_SLTU,   32'hFFFFFFFF, 32'd1,        32'd0,        0});
    tbl.push_back(vec_t'{UOP_SRA,    32'h80000000, 32'd4,        32'hF8000000, 0});
    tbl.push_back(vec_t'{UOP_SRL,    32'h80000000, 32'd4,        32'h08000000, 0});
    tbl.push_back(vec_t'{UOP_SLL,    32'd3,        32'd33,       32'd6,        0});
    tbl.push_back(vec_t'{5'h05,      32'd1,        32'd2,        32'd0,        0});
    tbl.push_back(vec_t'{5'h0C,      32'd1,        32'd2,        32'd0,        0});
    tbl.push_back(vec_t'{5'h18,      32'd9,        32'd9,        32'd0,        0});
    tbl.push_back(vec_t'{UOP_MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 33});
    tbl.push_back(vec_t'{UOP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
    tbl.push_back(vec_t'{UOP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    tbl.push_back(vec_t'{UOP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
    tbl.push_back(vec_t'{UOP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
    tbl.push_back(vec_t'{UOP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
    tbl.push_back(vec_t'{UOP_DIVU,   32'd100,      32'd7,        32'd14,       33});
    tbl.push_back(vec_t'{UOP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 0});
    tbl.push_back(vec_t'{UOP_REMU,   32'd5,        32'd0,        32'd5,        0});
    tbl.push_back(vec_t'{UOP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
    tbl.push_back(vec_t'{UOP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0});

    rst = 1'b1; flush = 1'b0; ready_in = 1'b1;
    valid_in = 1'b0; uop = '0; a = '0; b = '0;
    v16_in = 1'b0; uop16 = '0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", valid_out, 0);
    check("reset_result", result, 0);
    check("reset_ready", ready_out, 1);

    foreach (tbl[i]) begin
      run32(tbl[i].u, tbl[i].x, tbl[i].y, res, lat, leak);
      check($sformatf("tbl%0d_res", i), res, tbl[i].exp);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d_busy_ready", i), leak, 0);
    end
    @(negedge clk);

    // output hold with a competing op that must be ignored
    ready_in = 1'b0;
    run32(UOP_ADD, 32'd1, 32'd2, res, lat, leak);
    check("hold_first", res, 3);
    uop = UOP_SUB; a = 32'd9; b = 32'd9; valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", valid_out, 1);
      check("hold_result", result, 3);
      check("hold_ready", ready_out, 0);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
    check("drain_valid", valid_out, 0);
    check("drain_result", result, 3);

    // held multi-cycle result
    ready_in = 1'b0;
    run32(UOP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, leak);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mhold_valid", valid_out, 1);
      check("mhold_result", result, 32'hFFFFFFFE);
    end
    ready_in = 1'b1;
    @(negedge clk);
    check("mdrain_valid", valid_out, 0);

    // back-to-back single-cycle ops, one result per cycle
    for (int i = 0; i < 6; i++) begin
      uop = UOP_ADD; a = 32'(i * 3); b = 32'd100; valid_in = 1'b1;
      @(negedge clk);
      check("b2b_valid", valid_out, 1);
      check("b2b_result", result, 32'(i * 3 + 100));
      check("b2b_ready", ready_out, 1);
    end
    valid_in = 1'b0;

    // flush mid-divide
    uop = UOP_DIV; a = 32'd1000; b = 32'd7; valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", valid_out, 0);
    check("flush_ready", ready_out, 1);
    leak = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid_out) leak = 1'b1;
    end
    check("flush_quiet", leak, 0);

    // flush wins over a simultaneous accept
    uop = UOP_ADD; a = 32'd1; b = 32'd1; valid_in = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; flush = 1'b0;
    check("flush_accept_valid", valid_out, 0);
    check("flush_accept_result", result, 115);

    // async reset at iteration 10 of a multiply
    uop = UOP_MUL; a = 32'd12345; b = 32'd678; valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", valid_out, 0);
    check("rst_mid_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    leak = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid_out) leak = 1'b1;
    end
    check("rst_mid_quiet", leak, 0);

    for (int i = 0; i < 80; i++) begin
      u = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) u[4:3] = 2'b10;
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: begin x = 32'h80000000; y = '1; end
        2: begin x = 32'($urandom_range(0, 255)); y = 32'($urandom_range(1, 15)); end
        default: ;
      endcase
      e  = model(32, u, {32'd0, x}, {32'd0, y});
      el = lat_model(32, u, {32'd0, x}, {32'd0, y});
      run32(u, x, y, res, lat, leak);
      check($sformatf("rand_res u=%0h a=%0h b=%0h", u, x, y), res, e);
      check($sformatf("rand_lat u=%0h", u), lat, el);
      check("rand_busy_ready", leak, 0);
    end
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      u = {2'b10, 3'($urandom_range(0, 7))};
      if (i % 5 == 4) u = 5'($urandom_range(0, 15));
      x = 32'(16'($urandom));
      y = 32'(16'($urandom));
      case ($urandom_range(0, 5))
        0: y = '0;
        1: begin x = 32'h8000; y = 32'hFFFF; end
        default: ;
      endcase
      e  = model(16, u, {32'd0, x}, {32'd0, y});
      el = lat_model(16, u, {32'd0, x}, {32'd0, y});
      run16(u, x[15:0], y[15:0], r16, lat);
      check($sformatf("w16_res u=%0h a=%0h b=%0h", u, x, y), r16, e);
      check($sformatf("w16_lat u=%0h", u), lat, el);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
